mem_store_issuer: RTL and testbench
===================================

# mem_store_issuer

Store-side initiator for the MainMemory write packet port. It accepts word stores from the MEM pipeline stage over a valid/ready handshake and buffers them in a small FIFO. Same-word stores to the newest entry are coalesced. It drives the 65-bit `serial` write packet `{valid, word_addr, data}` consumed by MainMemory, at most one packet per cycle. It sits between the MEM stage and MainMemory, opposite the memory's packet receiver.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  block can accept; equals `!full` and depends only on registered state.
- `req_addr`  in  32  byte address of store.
- `req_data`  in  32  store data word.
- `hold`  in  1  memory busy; suppresses issue this edge.
- `serial`  out  65  registered write packet: [64] valid, [63:32] word address (`req_addr>>2`), [31:0] data.
- `idle`  out  1  FIFO empty and `serial[64]`==0.
- `misalign_err`  out  1  sticky; set by any accepted request with `req_addr[1:0]!=0`.

## Operation
- Accept: edge with `req_valid && req_ready`.
- Misaligned accept (`req_addr[1:0]!=0`):
  - Handshake completes and the store is dropped; it is never issued.
  - `misalign_err` <= 1 and stays 1 until reset.
- Aligned accept, coalesce: if FIFO non-empty, the tail (newest) entry's word address equals `req_addr[31:2]`, and the tail is not the entry being popped this edge, then overwrite the tail data. Count is unchanged.
- Aligned accept, otherwise: push `{req_addr[31:2], req_data}` at the tail.
- Issue: edge with `!hold` and FIFO non-empty:
  - `serial` <= `{1'b1, head_addr, head_data}`.
  - Pop the head.
- No issue (`hold`=1 or FIFO empty): `serial` <= 65'b0.
- Push and pop on the same edge are allowed; count is unchanged, or decrements by 1 on a merge+pop.
- Order: packets leave in acceptance order. A coalesced entry issues at its original position with the latest data.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A count register of log2(DEPTH)+1 bits distinguishes full from empty.
- Reset (async, any time, including mid-drain): pointers, count, `serial`, and `misalign_err` go to 0; buffered stores are discarded.
  - Reset values: `req_ready`=1, `idle`=1, `serial`=0, `misalign_err`=0.

## Timing
- Latency: a store accepted at edge N into an empty FIFO with `hold`=0 appears on `serial` after edge N+1. MainMemory commits it at edge N+2.
- No same-edge bypass: a request is never issued on its accept edge.
- Throughput: one packet per cycle while non-empty and `hold`=0. The `serial` valid bit is high for exactly one cycle per packet.
- `hold` is sampled at the edge. `hold`=1 at edge N means no packet after N and the FIFO head is retained.
- Full: `req_ready`=0 when count==DEPTH, even if a pop occurs that edge. A coalescible request at full is also stalled.
- `idle` is combinational from registered state.

## Test plan
- Reset/single store:
  - Stimulus: reset low, then high; accept addr 0x08, data 0x0000FFFF at edge N.
  - Required: before the accept, `serial`=0, `idle`=1, `req_ready`=1.
  - Required: after N+1, `serial` = {1, 0x00000002, 0x0000FFFF} for one cycle, then 0; `idle`=1 again.
- Fill and drain:
  - Stimulus: `hold`=1; accept addrs 0x0,0x4,0x8,0xC (data 1..4).
  - Required: `req_ready`=0 after the 4th accept.
  - Stimulus: drop `hold`.
  - Required: 4 consecutive packets with word addrs 0,1,2,3 and data 1..4; `req_ready` rises after the first pop.
- Coalesce:
  - Stimulus: `hold`=1; accept 0x10 data 0xA, then 0x10 data 0xB, then 0x14 data 0xC; release `hold`.
  - Required: exactly two packets, {1,4,0xB} then {1,5,0xC}.
- No merge into popping entry:
  - Stimulus: one entry at 0x20 popped at the same edge a new 0x20 store (data 0x2) is accepted.
  - Required: two packets to word 8, old data then 0x2.
- Misalign:
  - Stimulus: accept addr 0x06.
  - Required: handshake completes, no packet is issued, `misalign_err`=1 and stays 1 until reset.
- Wrap and reset mid-operation:
  - Stimulus: push/pop 10 stores with `hold` toggling.
  - Required: packets are issued in order across pointer wrap.
  - Stimulus: assert `RESET_N`=0 between edges with 3 entries queued.
  - Required: `serial`=0 and `idle`=1 immediately; no stale packet appears after release.

Source files
------------

// File: rtl/mem_store_issuer.sv
// Store-side packet initiator: buffers MEM-stage word stores, coalesces same-word stores into the
// newest entry, and issues one registered 65-bit write packet per cycle unless hold is asserted.
module mem_store_issuer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        hold,
  output logic [64:0] serial,
  output logic        idle,
  output logic        misalign_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [29:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [64:0]   serial_q, serial_d;
  logic          misalign_q, misalign_d;

  logic          empty;
  logic          accept;
  logic          aligned;
  logic [AW-1:0] tail_ptr;
  logic          do_pop;
  logic          do_merge;
  logic          do_push;

  always_comb begin
    empty     = (count_q == '0);
    req_ready = (count_q != FULL_CNT);
    accept    = req_valid && req_ready;
    aligned   = (req_addr[1:0] == 2'b00);
    tail_ptr  = wr_ptr_q - AW'(1);
    do_pop    = !hold && !empty;
    // With a single entry the tail is also the head; if it leaves this edge it must not absorb new data.
    do_merge  = accept && aligned && !empty && (addr_q[tail_ptr] == req_addr[31:2])
                && !(do_pop && (count_q == CW'(1)));
    do_push   = accept && aligned && !do_merge;
  end

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    serial_d   = '0;
    misalign_d = misalign_q | (accept & ~aligned);

    if (do_merge) begin
      data_d[tail_ptr] = req_data;
    end
    if (do_push) begin
      addr_d[wr_ptr_q] = req_addr[31:2];
      data_d[wr_ptr_q] = req_data;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      serial_d = {1'b1, 2'b00, addr_q[rd_ptr_q], data_q[rd_ptr_q]};
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      serial_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      serial_q   <= serial_d;
      misalign_q <= misalign_d;
    end
  end

  assign serial       = serial_q;
  assign misalign_err = misalign_q;
  assign idle         = empty && !serial_q[64];

endmodule

// File: tb/tb_mem_store_issuer.sv
// Randomized and directed bench for mem_store_issuer against a queue-based reference model.
module tb_mem_store_issuer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        hold = 1'b0;
  logic [64:0] serial;
  logic        idle;
  logic        misalign_err;

  int checks = 0;
  int failures = 0;

  mem_store_issuer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold), .serial(serial),
    .idle(idle), .misalign_err(misalign_err)
  );

  always #5 CLK = ~CLK;

  // Reference: an ordered list of {word_addr, data} stores awaiting issue.
  logic [63:0] mq[$];
  logic [64:0] exp_serial = '0;
  logic        exp_err = 1'b0;

  always @(posedge CLK or negedge RESET_N) begin : model
    bit acc, pop, push;
    logic [63:0] tmp;
    if (!RESET_N) begin
      mq.delete();
      exp_serial = '0;
      exp_err = 1'b0;
    end else begin
      acc  = req_valid && (mq.size() != DEPTH);
      pop  = !hold && (mq.size() != 0);
      push = 1'b0;
      exp_serial = pop ? {1'b1, mq[0]} : 65'b0;
      if (acc && req_addr[1:0] != 2'b00) begin
        exp_err = 1'b1;
      end else if (acc) begin
        if (mq.size() != 0 && mq[mq.size()-1][63:32] == {2'b00, req_addr[31:2]}
            && !(pop && mq.size() == 1)) begin
          tmp = mq[mq.size()-1];
          tmp[31:0] = req_data;
          mq[mq.size()-1] = tmp;
        end else begin
          push = 1'b1;
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({2'b00, req_addr[31:2], req_data});
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic h);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    hold      = h;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    checks++; if (serial !== 65'b0) begin failures++; $display("FAIL reset_serial got=%h exp=0", serial); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", misalign_err); end
  endtask

  task automatic test_single_store();
    drive(1'b1, 32'h8, 32'h0000FFFF, 1'b0);
    tick();
    checks++; if (serial !== 65'b0) begin failures++; $display("FAIL single_no_bypass got=%h exp=0", serial); end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (serial !== {1'b1, 32'h2, 32'h0000FFFF}) begin failures++; $display("FAIL single_pkt got=%h exp=%h", serial, {1'b1, 32'h2, 32'h0000FFFF}); end
    tick();
    checks++; if (serial !== 65'b0) begin failures++; $display("FAIL single_after got=%h exp=0", serial); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'(i + 1), 1'b1);
      tick();
    end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", req_ready); end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (serial !== {1'b1, 32'(i), 32'(i + 1)}) begin failures++; $display("FAIL drain_pkt%0d got=%h exp=%h", i, serial, {1'b1, 32'(i), 32'(i + 1)}); end
      if (i == 0) begin
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", req_ready); end
      end
    end
    tick();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_idle got=%b exp=1", idle); end
  endtask

  task automatic test_coalesce();
    logic [64:0] pk[$];
    drive(1'b1, 32'h10, 32'hA, 1'b1); tick();
    drive(1'b1, 32'h10, 32'hB, 1'b1); tick();
    drive(1'b1, 32'h14, 32'hC, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (serial[64] === 1'b1) pk.push_back(serial);
      checks++; if (serial !== exp_serial) begin failures++; $display("FAIL coalesce_model got=%h exp=%h", serial, exp_serial); end
    end
    checks++;
    if (pk.size() != 2) begin
      failures++; $display("FAIL coalesce_count got=%0d exp=2", pk.size());
    end else begin
      checks++; if (pk[0] !== {1'b1, 32'h4, 32'hB}) begin failures++; $display("FAIL coalesce_pkt0 got=%h exp=%h", pk[0], {1'b1, 32'h4, 32'hB}); end
      checks++; if (pk[1] !== {1'b1, 32'h5, 32'hC}) begin failures++; $display("FAIL coalesce_pkt1 got=%h exp=%h", pk[1], {1'b1, 32'h5, 32'hC}); end
    end
  endtask

  task automatic test_no_merge_popping();
    drive(1'b1, 32'h20, 32'h1, 1'b1); tick();
    drive(1'b1, 32'h20, 32'h2, 1'b0); tick();
    checks++; if (serial !== {1'b1, 32'h8, 32'h1}) begin failures++; $display("FAIL nomerge_pkt0 got=%h exp=%h", serial, {1'b1, 32'h8, 32'h1}); end
    drive(1'b0, 32'h0, 32'h0, 1'b0); tick();
    checks++; if (serial !== {1'b1, 32'h8, 32'h2}) begin failures++; $display("FAIL nomerge_pkt1 got=%h exp=%h", serial, {1'b1, 32'h8, 32'h2}); end
    tick();
    checks++; if (serial !== 65'b0) begin failures++; $display("FAIL nomerge_after got=%h exp=0", serial); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h6, 32'h55, 1'b0);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL misalign_ready got=%b exp=1", req_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (serial !== 65'b0) begin failures++; $display("FAIL misalign_serial got=%h exp=0", serial); end
      checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", misalign_err); end
      tick();
    end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL misalign_idle got=%b exp=1", idle); end
  endtask

  task automatic test_random();
    int pkts = 0;
    logic [31:0] a;
    for (int c = 0; c < 300; c++) begin
      a = 32'($urandom_range(0, 3)) << 2;
      if ($urandom_range(0, 15) == 0) a = a | 32'h1;
      drive(($urandom_range(0, 2) != 0), a, $urandom, ($urandom_range(0, 2) == 0));
      tick();
      if (serial[64] === 1'b1) pkts++;
      checks++; if (serial !== exp_serial) begin failures++; $display("FAIL rand_serial c=%0d got=%h exp=%h", c, serial, exp_serial); end
      checks++; if (req_ready !== (mq.size() != DEPTH)) begin failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, mq.size() != DEPTH); end
      checks++; if (idle !== (mq.size() == 0 && exp_serial[64] == 1'b0)) begin failures++; $display("FAIL rand_idle c=%0d got=%b", c, idle); end
      checks++; if (misalign_err !== exp_err) begin failures++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, misalign_err, exp_err); end
    end
    checks++; if (pkts < 10) begin failures++; $display("FAIL rand_pkts got=%0d exp>=10", pkts); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40 + 32'(i * 4), 32'(16 + i), 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (serial !== {1'b1, 32'h10, 32'h10}) begin failures++; $display("FAIL mid_pkt got=%h exp=%h", serial, {1'b1, 32'h10, 32'h10}); end
    checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mid_err_sticky got=%b exp=1", misalign_err); end
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (serial !== 65'b0) begin failures++; $display("FAIL mid_rst_serial got=%h exp=0", serial); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%b exp=1", idle); end
    checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b exp=0", misalign_err); end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (serial !== 65'b0) begin failures++; $display("FAIL mid_stale got=%h exp=0", serial); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b exp=1", idle); end
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill_drain();
    test_coalesce();
    test_no_merge_popping();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
